mac_dot_seq_ctrl: RTL and testbench

- Sequencer that drives one uint8×uint8→int32 MAC unit through a complete dot product of length N.
- Reads activation and weight operands from two 1-cycle-latency SRAM ports and asserts the MAC's clear and enable controls.
- Captures the final accumulator value and presents it on a valid/ready result interface.
- Sits between the layer scheduler (which issues start commands) and a single MAC lane in the MobileNetV2 inference datapath.

---
 rtl/mac_dot_seq_ctrl.sv | 162 ++++++++++++++++
 tb/tb_mac_dot_seq_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_dot_seq_ctrl.sv
// rtl/mac_dot_seq_ctrl.sv - dot-product sequencer driving one uint8 MAC lane; optional counters via MAC_DOT_SEQ_PERF_EN
module mac_dot_seq_ctrl #(
  parameter int ADDR_W = 12,
  parameter int LEN_W  = 12
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  vec_len,
  input  logic [ADDR_W-1:0] act_base,
  input  logic [ADDR_W-1:0] wgt_base,
  input  logic              abort,
  output logic              busy,
  output logic              act_rd_en,
  output logic [ADDR_W-1:0] act_rd_addr,
  output logic              wgt_rd_en,
  output logic [ADDR_W-1:0] wgt_rd_addr,
  output logic              mac_clear,
  output logic              mac_enable,
  input  logic [31:0]       mac_acc,
  output logic [31:0]       result_data,
  output logic              result_valid,
  input  logic              result_ready
`ifdef MAC_DOT_SEQ_PERF_EN
  ,
  output logic [31:0]       perf_ops,
  output logic [31:0]       perf_busy_cycles
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_STREAM,
    S_DRAIN,
    S_CAPTURE,
    S_OUTPUT
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  idx_q;
  logic [LEN_W-1:0]  idx_inc;
  logic [ADDR_W-1:0] act_base_q;
  logic [ADDR_W-1:0] wgt_base_q;
  logic              rd_issue;
  logic              accept;
  logic              capture;
  logic              handshake;

  assign idx_inc = idx_q + LEN_W'(1);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    rd_issue     = 1'b0;
    mac_clear    = 1'b0;
    result_valid = 1'b0;
    accept       = 1'b0;
    capture      = 1'b0;
    handshake    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = S_CLEAR;
        end
      end
      S_CLEAR: begin
        mac_clear = 1'b1;
        rd_issue  = (len_q != '0);
        state_nxt = (len_q > LEN_W'(1)) ? S_STREAM : S_DRAIN;
      end
      S_STREAM: begin
        rd_issue = 1'b1;
        if (idx_inc == len_q) begin
          state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        state_nxt = S_CAPTURE;
      end
      S_CAPTURE: begin
        capture   = 1'b1;
        state_nxt = S_OUTPUT;
      end
      S_OUTPUT: begin
        result_valid = 1'b1;
        if (result_ready) begin
          handshake = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
    // abort outranks start, capture and the result handshake
    if (abort) begin
      state_nxt = S_IDLE;
      accept    = 1'b0;
      capture   = 1'b0;
      handshake = 1'b0;
    end
  end

  assign busy        = (state != S_IDLE);
  assign act_rd_en   = rd_issue;
  assign wgt_rd_en   = rd_issue;
  assign act_rd_addr = rd_issue ? (act_base_q + ADDR_W'(idx_q)) : '0;
  assign wgt_rd_addr = rd_issue ? (wgt_base_q + ADDR_W'(idx_q)) : '0;

  // mac_enable trails the read strobe by one cycle to line up with SRAM data
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      len_q       <= '0;
      idx_q       <= '0;
      act_base_q  <= '0;
      wgt_base_q  <= '0;
      mac_enable  <= 1'b0;
      result_data <= '0;
    end else begin
      if (accept) begin
        len_q      <= vec_len;
        act_base_q <= act_base;
        wgt_base_q <= wgt_base;
        idx_q      <= '0;
      end else if (rd_issue) begin
        idx_q <= idx_inc;
      end
      mac_enable <= rd_issue & ~abort;
      if (capture) begin
        result_data <= mac_acc;
      end
    end
  end

`ifdef MAC_DOT_SEQ_PERF_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      perf_ops         <= '0;
      perf_busy_cycles <= '0;
    end else begin
      if (handshake) begin
        perf_ops <= perf_ops + 32'd1;
      end
      if (busy) begin
        perf_busy_cycles <= perf_busy_cycles + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mac_dot_seq_ctrl.sv
// tb/tb_mac_dot_seq_ctrl.sv - randomized scoreboard bench for mac_dot_seq_ctrl
module tb_mac_dot_seq_ctrl;
  localparam int AW = 12;
  localparam int LW = 12;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          result_ready = 1'b0;
  logic [LW-1:0] vec_len = '0;
  logic [AW-1:0] act_base = '0;
  logic [AW-1:0] wgt_base = '0;
  logic          busy, act_rd_en, wgt_rd_en, mac_clear, mac_enable, result_valid;
  logic [AW-1:0] act_rd_addr, wgt_rd_addr;
  logic [31:0]   mac_acc, result_data;
`ifdef MAC_DOT_SEQ_PERF_EN
  logic [31:0]   perf_ops, perf_busy_cycles;
`endif

  always #5 clock = ~clock;

  mac_dot_seq_ctrl #(.ADDR_W(AW), .LEN_W(LW)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .vec_len(vec_len),
    .act_base(act_base), .wgt_base(wgt_base), .abort(abort), .busy(busy),
    .act_rd_en(act_rd_en), .act_rd_addr(act_rd_addr), .wgt_rd_en(wgt_rd_en),
    .wgt_rd_addr(wgt_rd_addr), .mac_clear(mac_clear), .mac_enable(mac_enable),
    .mac_acc(mac_acc), .result_data(result_data), .result_valid(result_valid),
    .result_ready(result_ready)
`ifdef MAC_DOT_SEQ_PERF_EN
    , .perf_ops(perf_ops), .perf_busy_cycles(perf_busy_cycles)
`endif
  );

  // environment: two 1-cycle-latency SRAMs and a wrapping uint8 MAC
  logic [7:0]  act_mem [4096];
  logic [7:0]  wgt_mem [4096];
  logic [7:0]  act_q = '0;
  logic [7:0]  wgt_q = '0;
  logic [31:0] acc = '0;
  assign mac_acc = acc;

  always @(posedge clock) begin
    if (act_rd_en) act_q <= act_mem[act_rd_addr];
    if (wgt_rd_en) wgt_q <= wgt_mem[wgt_rd_addr];
    if (mac_clear) acc <= '0;
    else if (mac_enable) acc <= acc + 32'(act_q) * 32'(wgt_q);
  end

  int total = 0;
  int bad = 0;
  logic [31:0] exp_res [$];
  logic [AW-1:0] exp_act [$];
  logic [AW-1:0] exp_wgt [$];
  int en_cnt = 0;
  int clr_cnt = 0;
  int ops_seen = 0;
  int busy_seen = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, want, want);
    end
  endtask

  // monitor: pops the scoreboard whenever the DUT presents a read or a result
  logic        prev_valid = 1'b0;
  logic        prev_ready = 1'b0;
  logic        prev_abort = 1'b0;
  logic [31:0] prev_data = '0;
  logic [AW-1:0] ea, ew;

  always @(negedge clock) begin
    if (!reset_n) begin
      ops_seen = 0;
      busy_seen = 0;
      prev_valid = 1'b0;
      exp_act.delete();
      exp_wgt.delete();
      exp_res.delete();
    end else begin
      if (busy) busy_seen++;
      if (mac_enable) en_cnt++;
      if (mac_clear) begin
        clr_cnt++;
        chk("enable_during_clear", mac_enable, 0);
      end
      if (act_rd_en || wgt_rd_en) begin
        chk("wgt_rd_en_eq_act", wgt_rd_en, act_rd_en);
        if (exp_act.size() == 0) chk("unexpected_read", exp_act.size(), 1);
        else begin
          ea = exp_act.pop_front();
          ew = exp_wgt.pop_front();
          chk("act_rd_addr", act_rd_addr, ea);
          chk("wgt_rd_addr", wgt_rd_addr, ew);
        end
      end
      if (prev_valid && !prev_ready && !prev_abort) begin
        chk("valid_held", result_valid, 1);
        chk("data_held", result_data, prev_data);
      end
      if (result_valid && result_ready && !abort) begin
        ops_seen++;
        if (exp_res.size() == 0) chk("unexpected_result", exp_res.size(), 1);
        else chk("result_data", result_data, exp_res.pop_front());
      end
      if (abort) begin
        exp_act.delete();
        exp_wgt.delete();
        exp_res.delete();
      end
      prev_valid = result_valid;
      prev_ready = result_ready;
      prev_abort = abort;
      prev_data = result_data;
    end
  end

  task automatic push_expect(input int n, input logic [AW-1:0] ab, input logic [AW-1:0] wb,
                             input bit with_result);
    logic [31:0] sum;
    logic [AW-1:0] a, w;
    sum = '0;
    for (int i = 0; i < n; i++) begin
      a = ab + i[AW-1:0];
      w = wb + i[AW-1:0];
      sum += 32'(act_mem[a]) * 32'(wgt_mem[w]);
      exp_act.push_back(a);
      exp_wgt.push_back(w);
    end
    if (with_result) exp_res.push_back(sum);
  endtask

  // mode 0: ready held high, 1: random ready plus a stray start, 2: 10-cycle stall with start pulses
  task automatic run_op(input int n, input logic [AW-1:0] ab, input logic [AW-1:0] wb, input int mode);
    int e0, c0, lat, cnt;
    push_expect(n, ab, wb, 1'b1);
    e0 = en_cnt;
    c0 = clr_cnt;
    result_ready = (mode == 0);
    vec_len = n[LW-1:0];
    act_base = ab;
    wgt_base = wb;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    lat = 0;
    while (!result_valid && lat < 100) begin
      if (mode == 1 && lat == 1) begin
        start = 1'b1;
        vec_len = LW'($urandom_range(1, 30));
        act_base = AW'($urandom);
        wgt_base = AW'($urandom);
      end else start = 1'b0;
      @(posedge clock); #1;
      lat++;
    end
    start = 1'b0;
    chk("latency", lat, (n == 0) ? 3 : n + 2);
    cnt = 0;
    while (result_valid && cnt < 200) begin
      if (mode == 1) result_ready = 1'($urandom);
      if (mode == 2) begin
        if (cnt < 10) begin
          result_ready = 1'b0;
          start = cnt[0];
          vec_len = 12'd5;
          act_base = 12'h123;
          wgt_base = 12'h456;
        end else begin
          start = 1'b0;
          result_ready = 1'b1;
        end
      end
      @(posedge clock); #1;
      cnt++;
    end
    start = 1'b0;
    result_ready = 1'b0;
    if (mode == 2) chk("stall_release_cycles", cnt, 11);
    chk("handshake_done", result_valid, 0);
    chk("busy_after_op", busy, 0);
    chk("mac_enable_count", en_cnt - e0, n);
    chk("mac_clear_count", clr_cnt - c0, 1);
    chk("reads_outstanding", exp_act.size(), 0);
    @(posedge clock); #1;
    chk("stays_idle", busy, 0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_act_rd_en"}, act_rd_en, 0);
    chk({tag, "_act_rd_addr"}, act_rd_addr, 0);
    chk({tag, "_wgt_rd_en"}, wgt_rd_en, 0);
    chk({tag, "_wgt_rd_addr"}, wgt_rd_addr, 0);
    chk({tag, "_mac_clear"}, mac_clear, 0);
    chk({tag, "_mac_enable"}, mac_enable, 0);
    chk({tag, "_result_data"}, result_data, 0);
    chk({tag, "_result_valid"}, result_valid, 0);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      act_mem[i] = 8'($urandom);
      wgt_mem[i] = 8'($urandom);
    end
    #12;
    check_all_zero("reset");
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(posedge clock); #1;

    for (int i = 0; i < 4; i++) begin
      act_mem[12'h010 + i] = 8'(i + 1);
      wgt_mem[12'h200 + i] = 8'(i + 5);
    end
    run_op(4, 12'h010, 12'h200, 0);
    act_mem[12'h300] = 8'd255;
    wgt_mem[12'h700] = 8'd255;
    run_op(1, 12'h300, 12'h700, 0);
    run_op(0, 12'h055, 12'h066, 0);
    run_op(4, 12'hFFE, 12'h7FE, 0);
    run_op(3, 12'h020, 12'h220, 2);

    // abort mid-stream at idx 7, with start and ready also high that cycle
    push_expect(16, 12'h400, 12'h800, 1'b0);
    vec_len = 12'd16;
    act_base = 12'h400;
    wgt_base = 12'h800;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (7) @(posedge clock);
    #1;
    abort = 1'b1;
    start = 1'b1;
    result_ready = 1'b1;
    @(posedge clock); #1;
    abort = 1'b0;
    start = 1'b0;
    result_ready = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_act_rd_en", act_rd_en, 0);
    chk("abort_wgt_rd_en", wgt_rd_en, 0);
    chk("abort_mac_enable", mac_enable, 0);
    chk("abort_mac_clear", mac_clear, 0);
    chk("abort_result_valid", result_valid, 0);
    @(posedge clock); #1;
    chk("abort_start_ignored", busy, 0);
    run_op(2, 12'h600, 12'h900, 0);

    for (int k = 0; k < 12; k++) begin
      run_op($urandom_range(0, 20), AW'($urandom), AW'($urandom), 1);
    end

    // asynchronous reset mid-stream
    push_expect(16, 12'hA00, 12'hB00, 1'b1);
    vec_len = 12'd16;
    act_base = 12'hA00;
    wgt_base = 12'hB00;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (5) @(posedge clock);
    #3;
    reset_n = 1'b0;
    #1;
    check_all_zero("midreset");
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(posedge clock); #1;

    for (int k = 0; k < 3; k++) begin
      run_op($urandom_range(1, 10), AW'($urandom), AW'($urandom), 0);
    end
    chk("ops_after_reset", ops_seen, 3);
`ifdef MAC_DOT_SEQ_PERF_EN
    chk("perf_ops", perf_ops, ops_seen);
    chk("perf_busy_cycles", perf_busy_cycles, busy_seen);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
